mem_bus_master: RTL and testbench

- Avalon-MM master stage between the CPU datapath and the memory bus.
- Accepts one load or store request at a time and issues a word-aligned bus transaction.
- Steers store data and byte enables onto the correct lanes.
- Holds off on waitrequest, then registers the raw read word and its low address bits.
- Those registered outputs feed the downstream load byte-extraction stage (bytes_control) directly.

---
 rtl/mem_bus_master_pkg.sv | 23 ++
 rtl/mem_bus_master_if.sv | 38 +++
 rtl/mem_bus_master_store_lane_steer.sv | 15 +
 rtl/mem_bus_master.sv | 115 +++++++++++
 tb/tb_mem_bus_master.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: MIPS load/store opcodes, FSM state encoding and opcode class helpers
package mem_bus_master_pkg;
  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LWL = 6'h22;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_LWR = 6'h26;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2b;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUS  = 2'd1;
  localparam state_t RESP = 2'd2;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW, OPCODE_LWL, OPCODE_LWR};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {OPCODE_SB, OPCODE_SH, OPCODE_SW};
  endfunction
endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: request/response handshake plus Avalon-MM bus (bus_error only with MEM_BUS_TIMEOUT_EN)
interface mem_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_lsb;
  logic [5:0]  resp_opcode;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
`ifdef MEM_BUS_TIMEOUT_EN
  logic        bus_error;
`endif
  modport master (
    input  req_valid, req_opcode, req_addr, req_wdata, waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_lsb, resp_opcode,
    output address, read, write, byteenable, writedata
`ifdef MEM_BUS_TIMEOUT_EN
    , output bus_error
`endif
  );
  modport slave (
    output req_valid, req_opcode, req_addr, req_wdata, waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_lsb, resp_opcode,
    input  address, read, write, byteenable, writedata
`ifdef MEM_BUS_TIMEOUT_EN
    , input bus_error
`endif
  );
endinterface

// File: rtl/mem_bus_master_store_lane_steer.sv
// store_lane_steer: replicates store data across lanes and derives byte enables from opcode and address lsbs
module store_lane_steer
  import mem_bus_master_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  lsb,
  input  logic [31:0] wdata,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable
);
  always_comb begin
    writedata  = opcode == OPCODE_SB ? {4{wdata[7:0]}} : opcode == OPCODE_SH ? {2{wdata[15:0]}} : wdata;
    byteenable = opcode == OPCODE_SB ? 4'b0001 << lsb : opcode == OPCODE_SH ? (lsb[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding Avalon-MM load/store master (IDLE/BUS/RESP), optional timeout via MEM_BUS_TIMEOUT_EN
module mem_bus_master
  import mem_bus_master_pkg::*;
`ifdef MEM_BUS_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
)
`endif
(
  input logic             clk,
  input logic             reset,
  mem_bus_master_if.master bus
);
  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [31:0] steer_wdata;
  logic [3:0]  steer_be;
  logic        accept;
  store_lane_steer u_steer (
    .opcode    (bus.req_opcode),
    .lsb       (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .writedata (steer_wdata),
    .byteenable(steer_be)
  );
  assign accept = state_q == IDLE && bus.req_valid && (is_load(bus.req_opcode) || is_store(bus.req_opcode));
`ifdef MEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  assign timeout = state_q == BUS && bus.waitrequest && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d = accept ? '0 : state_q == BUS && bus.waitrequest ? cnt_q + 1'b1 : cnt_q;
    err_d = accept ? 1'b0 : timeout ? 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.bus_error = err_q;
`endif
  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    lsb_d    = lsb_q;
    opcode_d = opcode_q;
    if (accept) begin
      state_d  = BUS;
      load_d   = is_load(bus.req_opcode);
      addr_d   = bus.req_addr[31:2];
      be_d     = steer_be;
      wdata_d  = steer_wdata;
      lsb_d    = bus.req_addr[1:0];
      opcode_d = bus.req_opcode;
    end
    if (state_q == BUS && !bus.waitrequest) begin
      state_d = RESP;
      rdata_d = load_q ? bus.readdata : rdata_q;
    end
`ifdef MEM_BUS_TIMEOUT_EN
    if (timeout) begin
      state_d = RESP;
      rdata_d = load_q ? '0 : rdata_q;
    end
`endif
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lsb_q    <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      lsb_q    <= lsb_d;
      opcode_q <= opcode_d;
    end
  end
  assign bus.req_ready   = state_q == IDLE;
  assign bus.resp_valid  = state_q == RESP;
  assign bus.read        = state_q == BUS && load_q;
  assign bus.write       = state_q == BUS && !load_q;
  assign bus.address     = {addr_q, 2'b00};
  assign bus.byteenable  = be_q;
  assign bus.writedata   = wdata_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_lsb    = lsb_q;
  assign bus.resp_opcode = opcode_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: table-driven load/store vectors plus reset, illegal-opcode and timeout sequences
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_address;
    logic        exp_read;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_lsb;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs [8];
  mem_bus_master_if bus ();
`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));
`else
  mem_bus_master dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_opcode  = v.op;
    bus.req_addr    = v.addr;
    bus.req_wdata   = v.wdata;
    bus.readdata    = v.rdata;
    bus.waitrequest = v.waits > 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= v.waits + 1; k++) begin
      chk({v.name, " req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({v.name, " resp_valid_bus"}, 32'(bus.resp_valid), 32'd0);
      chk({v.name, " read"}, 32'(bus.read), 32'(v.exp_read));
      chk({v.name, " write"}, 32'(bus.write), 32'(!v.exp_read));
      chk({v.name, " address"}, bus.address, v.exp_address);
      chk({v.name, " byteenable"}, 32'(bus.byteenable), 32'(v.exp_be));
      if (!v.exp_read) chk({v.name, " writedata"}, bus.writedata, v.exp_wd);
      bus.waitrequest = k <= v.waits;
      @(negedge clk);
    end
    chk({v.name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({v.name, " resp_rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({v.name, " resp_lsb"}, 32'(bus.resp_lsb), 32'(v.exp_lsb));
    chk({v.name, " resp_opcode"}, 32'(bus.resp_opcode), 32'(v.op));
    chk({v.name, " rw_off_resp"}, 32'({bus.read, bus.write}), 32'd0);
`ifdef MEM_BUS_TIMEOUT_EN
    chk({v.name, " bus_error"}, 32'(bus.bus_error), 32'd0);
`endif
    @(negedge clk);
    chk({v.name, " resp_valid_done"}, 32'(bus.resp_valid), 32'd0);
    chk({v.name, " req_ready_done"}, 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    vecs[0] = '{"LW",  OPCODE_LW,  32'h1004, 32'h0,        32'hDEADBEEF, 0, 32'h1004, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 2'd0};
    vecs[1] = '{"SB",  OPCODE_SB,  32'h2003, 32'h000000A5, 32'h11111111, 0, 32'h2000, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF, 2'd3};
    vecs[2] = '{"SH2", OPCODE_SH,  32'h3002, 32'h00001234, 32'h22222222, 0, 32'h3000, 1'b0, 4'b1100, 32'h12341234, 32'hDEADBEEF, 2'd2};
    vecs[3] = '{"SH0", OPCODE_SH,  32'h3000, 32'h00001234, 32'h33333333, 0, 32'h3000, 1'b0, 4'b0011, 32'h12341234, 32'hDEADBEEF, 2'd0};
    vecs[4] = '{"SW",  OPCODE_SW,  32'h5008, 32'hCAFEF00D, 32'h44444444, 0, 32'h5008, 1'b0, 4'b1111, 32'hCAFEF00D, 32'hDEADBEEF, 2'd0};
    vecs[5] = '{"LBU", OPCODE_LBU, 32'h6002, 32'h0,        32'h01234567, 0, 32'h6000, 1'b1, 4'b1111, 32'h0,        32'h01234567, 2'd2};
    vecs[6] = '{"LB",  OPCODE_LB,  32'h4001, 32'h0,        32'h80FF7F01, 3, 32'h4000, 1'b1, 4'b1111, 32'h0,        32'h80FF7F01, 2'd1};
    vecs[7] = '{"LWR", OPCODE_LWR, 32'h700B, 32'h0,        32'h5A5A0F0F, 1, 32'h7008, 1'b1, 4'b1111, 32'h0,        32'h5A5A0F0F, 2'd3};
    bus.req_valid   = 1'b0;
    bus.req_opcode  = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst rw", 32'({bus.read, bus.write}), 32'd0);
    chk("rst address", bus.address, 32'd0);
    chk("rst byteenable", 32'(bus.byteenable), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    reset = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_opcode = 6'h00;
    bus.req_addr   = 32'h8000;
    @(negedge clk);
    chk("illegal req_ready", 32'(bus.req_ready), 32'd1);
    chk("illegal rw", 32'({bus.read, bus.write}), 32'd0);
    chk("illegal address", bus.address, 32'h7008);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_opcode  = OPCODE_LW;
    bus.req_addr    = 32'h9000;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort read_before", 32'(bus.read), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort read_async", 32'(bus.read), 32'd0);
    chk("abort req_ready_async", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort no_resp", 32'(bus.resp_valid), 32'd0);
      chk("abort req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
    end
`ifdef MEM_BUS_TIMEOUT_EN
    bus.req_valid   = 1'b1;
    bus.req_opcode  = OPCODE_LW;
    bus.req_addr    = 32'hA004;
    bus.waitrequest = 1'b1;
    bus.readdata    = 32'hFFFFFFFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("tmo read_held", 32'(bus.read), 32'd1);
      chk("tmo resp_pending", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("tmo resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("tmo bus_error", 32'(bus.bus_error), 32'd1);
    chk("tmo read_off", 32'(bus.read), 32'd0);
    chk("tmo resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    chk("tmo resp_done", 32'(bus.resp_valid), 32'd0);
    chk("tmo err_held", 32'(bus.bus_error), 32'd1);
    bus.waitrequest = 1'b0;
    run_vec(vecs[0]);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
